// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives the instruction memory fetch port and buffers results for decode
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic [7:0]  im_pc,
    output logic        im_fetch_enable,
    input  logic [19:0] im_instruction,
    input  logic        im_instruction_ready,
    output logic        instr_valid,
    output logic [19:0] instr,
    output logic [7:0]  instr_pc,
    input  logic        instr_ready,
    output logic        running
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, HALTED} state_t;

    localparam logic [1:0] DEPTH_C = DEPTH[1:0];

    state_t      state_q, state_d;
    logic [7:0]  fetch_pc_q, fetch_pc_d, im_pc_q;
    logic [27:0] buf_q [2];
    logic        head_q, tail_q;
    logic [1:0]  count_q;
    logic        push, pop, flush;

    assign im_pc       = im_pc_q;
    assign instr_valid = count_q != 2'd0;
    assign instr       = buf_q[head_q][19:0];
    assign instr_pc    = buf_q[head_q][27:20];
    assign running     = state_q == ISSUE || state_q == WAIT || state_q == DRAIN;

    // Next state, fetch request and buffer controls; a redirect outranks push and pop
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        flush           = redirect_valid && state_q != IDLE;
        pop             = instr_valid && instr_ready && !flush;
        push            = state_q == WAIT && im_instruction_ready && !redirect_valid;
        im_fetch_enable = state_q == ISSUE && count_q < DEPTH_C && !halt_req && !redirect_valid;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (!redirect_valid) state_d = halt_req ? HALTED : im_fetch_enable ? WAIT : ISSUE;
            WAIT:    if (im_instruction_ready) state_d = (halt_req && !redirect_valid) ? HALTED : ISSUE;
                     else if (redirect_valid) state_d = DRAIN;
            DRAIN:   if (im_instruction_ready) state_d = ISSUE;
            HALTED:  if (start && !halt_req) state_d = ISSUE;
            default: state_d = IDLE;
        endcase
        if (flush) fetch_pc_d = redirect_pc;
        else if (push) fetch_pc_d = fetch_pc_q + 8'd3;
    end

    // State, fetch PC and the memory address, which holds for the whole outstanding fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            im_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (im_fetch_enable) im_pc_q <= fetch_pc_q;
        end
    end

    // Two-entry FIFO of {pc, instruction}; flush empties it in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                buf_q[tail_q] <= {fetch_pc_q, im_instruction};
                tail_q        <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
